// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
//   mult_state_t : sequencer FSM states
//   FN_ADD/FN_SUB: adder function select encodings driven on fn_o
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        DONE
    } mult_state_t;

    localparam logic FN_ADD = 1'b0;
    localparam logic FN_SUB = 1'b1;

endpackage

// File: rtl/mult_sequencer_if.sv
// Control bundle between the multiplier sequencer and the A/X/B datapath.
//   run_i, load_i : debounced run / load levels from the top level
//   m0_i          : current LSB of the B register
//   shift_en_o, fn_o, load_a_o, clear_xa_o, load_b_o : datapath strobes
//   busy_o, done_o: status for the top level and display logic
// master = sequencer side, slave = datapath / top-level side.
interface mult_sequencer_if;

    logic run_i;
    logic load_i;
    logic m0_i;
    logic shift_en_o;
    logic fn_o;
    logic load_a_o;
    logic clear_xa_o;
    logic load_b_o;
    logic busy_o;
    logic done_o;

    modport master (
        input  run_i, load_i, m0_i,
        output shift_en_o, fn_o, load_a_o, clear_xa_o, load_b_o, busy_o, done_o
    );

    modport slave (
        output run_i, load_i, m0_i,
        input  shift_en_o, fn_o, load_a_o, clear_xa_o, load_b_o, busy_o, done_o
    );

endinterface

// File: rtl/run_posedge_detect.sv
// Rising-edge detector for the run level.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   run   : synchronized run level
//   start : one-cycle pulse when run goes 0 -> 1
module run_posedge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic start
);

    logic run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run;
        end
    end

    assign start = run & ~run_q;

endmodule

// File: rtl/mult_sequencer.sv
// Sequencer for a shift-add two's-complement multiplier (A/X/B shift registers plus a
// 9-bit add/sub unit). Runs WIDTH add/shift iterations per run-level rising edge; the
// last iteration subtracts. All strobes are decoded combinationally from state, cnt,
// m0_i and load_i.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus          : mult_sequencer_if.master (run/load/m0 in, strobes and status out)
// Build option MULT_SKIP_ZERO_EN: when defined, an iteration with m0_i = 0 shifts
// directly from ADD in one cycle instead of spending a separate SHIFT cycle.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic             Clk,
    input logic             Reset_n,
    mult_sequencer_if.master bus
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    mult_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            start;
    logic            last_iter;

    run_posedge_detect u_run_edge (
        .clk   (Clk),
        .rst_n (Reset_n),
        .run   (bus.run_i),
        .start (start)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_iter = (cnt_q == CntLast);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus.shift_en_o = 1'b0;
        bus.fn_o       = FN_ADD;
        bus.load_a_o   = 1'b0;
        bus.clear_xa_o = 1'b0;
        bus.load_b_o   = 1'b0;
        bus.busy_o     = 1'b0;
        bus.done_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Load takes priority; a coincident run edge is consumed and lost.
                if (bus.load_i) begin
                    bus.load_b_o   = 1'b1;
                    bus.clear_xa_o = 1'b1;
                end else if (start) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                bus.clear_xa_o = 1'b1;
                bus.busy_o     = 1'b1;
                cnt_d          = '0;
                state_d        = ADD;
            end
            ADD: begin
                bus.busy_o = 1'b1;
                bus.fn_o   = last_iter ? FN_SUB : FN_ADD;
`ifdef MULT_SKIP_ZERO_EN
                if (bus.m0_i) begin
                    bus.load_a_o = 1'b1;
                    state_d      = SHIFT;
                end else begin
                    // Nothing to add: fold the shift into this cycle.
                    bus.shift_en_o = 1'b1;
                    if (last_iter) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`else
                bus.load_a_o = bus.m0_i;
                state_d      = SHIFT;
`endif
            end
            SHIFT: begin
                bus.shift_en_o = 1'b1;
                bus.busy_o     = 1'b1;
                if (last_iter) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ADD;
                end
            end
            DONE: begin
                bus.done_o = 1'b1;
                if (!bus.run_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer (WIDTH = 8). A behavioural A/X/B datapath model
// follows the DUT strobes; expected products and latencies are queued when a run is
// launched and checked when done_o appears.
module tb_mult_sequencer;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [15:0] product;
        int          latency;
        int          nload;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    mult_sequencer_if bus ();

    mult_sequencer #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [7:0] last_lo = 8'h00;

    // Datapath model: switches, A, X, B.
    logic [7:0] sw = 8'h00;
    logic [7:0] a_mdl = 8'h00;
    logic       x_mdl = 1'b0;
    logic [7:0] b_mdl = 8'h00;
    logic [8:0] sum9;

    assign sum9 = {a_mdl[7], a_mdl} + (bus.fn_o ? (~{sw[7], sw} + 9'd1) : {sw[7], sw});
    assign bus.m0_i = b_mdl[0];

    always @(posedge Clk) begin
        if (bus.load_b_o) b_mdl <= sw;
        if (bus.clear_xa_o) begin
            a_mdl <= 8'h00;
            x_mdl <= 1'b0;
        end else if (bus.load_a_o) begin
            x_mdl <= sum9[8];
            a_mdl <= sum9[7:0];
        end else if (bus.shift_en_o) begin
            a_mdl <= {x_mdl, a_mdl[7:1]};
            b_mdl <= {a_mdl[0], b_mdl[7:1]};
        end
    end

    function automatic logic [5:0] outs();
        return {bus.shift_en_o, bus.load_a_o, bus.clear_xa_o, bus.load_b_o,
                bus.busy_o, bus.done_o};
    endfunction

    // Load B (optional), launch a run and check the whole sequence via the scoreboard.
    task automatic run_mult(input logic [7:0] s, input logic do_load, input logic [7:0] b_new,
                            input logic glitch);
        exp_t e;
        exp_t got_e;
        logic [7:0] b_used;
        logic signed [15:0] p;
        int nload = 0;
        int nshift = 0;
        int done_k = -1;
        @(negedge Clk);
        bus.run_i = 1'b0;
        if (do_load) begin
            sw = b_new;
            bus.load_i = 1'b1;
            @(negedge Clk);
            bus.load_i = 1'b0;
            b_used = b_new;
        end else begin
            b_used = last_lo;
        end
        sw = s;
        p = $signed({{8{s[7]}}, s}) * $signed({{8{b_used[7]}}, b_used});
        e.product = p;
        e.nload   = $countones(b_used);
`ifdef MULT_SKIP_ZERO_EN
        e.latency = 2 + WIDTH + $countones(b_used);
`else
        e.latency = 2 * WIDTH + 2;
`endif
        sb_q.push_back(e);
        bus.run_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                checks++;
                if ({bus.clear_xa_o, bus.busy_o} !== 2'b11) begin
                    errors++;
                    $display("FAIL clr_cycle: clear/busy=%b required 11", {bus.clear_xa_o, bus.busy_o});
                end
            end
            checks++;
            if (bus.load_a_o === 1'b1 && bus.shift_en_o === 1'b1) begin
                errors++;
                $display("FAIL exclusive: load_a and shift_en both high at k=%0d", k);
            end
            if (bus.load_a_o === 1'b1) begin
                nload++;
                checks++;
                if (bus.fn_o !== (nshift == WIDTH - 1)) begin
                    errors++;
                    $display("FAIL fn_sel: fn_o=%b at iteration %0d required %b", bus.fn_o,
                             nshift, (nshift == WIDTH - 1));
                end
            end
            if (bus.shift_en_o === 1'b1) nshift++;
            if (glitch && k == 4) bus.run_i = 1'b0;
            if (glitch && k == 5) bus.run_i = 1'b1;
            if (bus.done_o === 1'b1) begin
                done_k = k;
                break;
            end
        end
        got_e = sb_q.pop_front();
        checks++;
        if (done_k < 0) begin
            errors++;
            $display("FAIL done_timeout: done_o not seen within 40 cycles");
        end else if (done_k != got_e.latency) begin
            errors++;
            $display("FAIL latency: done at t+%0d required t+%0d", done_k, got_e.latency);
        end
        checks++;
        if ({a_mdl, b_mdl} !== got_e.product) begin
            errors++;
            $display("FAIL product: A:B=%h required %h", {a_mdl, b_mdl}, got_e.product);
        end
        checks++;
        if (nshift != WIDTH) begin
            errors++;
            $display("FAIL shift_count: %0d required %0d", nshift, WIDTH);
        end
        checks++;
        if (nload != got_e.nload) begin
            errors++;
            $display("FAIL load_count: %0d required %0d", nload, got_e.nload);
        end
        last_lo = got_e.product[7:0];
    endtask

    task automatic release_run();
        @(negedge Clk);
        bus.run_i = 1'b0;
        @(negedge Clk);
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL release: outputs=%b required 000000", outs());
        end
    endtask

    task automatic test_reset();
        bus.run_i  = 1'b0;
        bus.load_i = 1'b0;
        Reset_n    = 1'b0;
        #1;
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: outputs=%b required 000000", outs());
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL post_reset_idle: outputs=%b required 000000", outs());
        end
    endtask

    task automatic test_load();
        @(negedge Clk);
        sw = 8'h05;
        bus.load_i = 1'b1;
        #1;
        checks++;
        if ({bus.load_b_o, bus.clear_xa_o, bus.busy_o} !== 3'b110) begin
            errors++;
            $display("FAIL load_strobe: load_b/clear/busy=%b required 110",
                     {bus.load_b_o, bus.clear_xa_o, bus.busy_o});
        end
        @(negedge Clk);
        bus.load_i = 1'b0;
        #1;
        checks++;
        if ({bus.load_b_o, bus.clear_xa_o} !== 2'b00) begin
            errors++;
            $display("FAIL load_single: load_b/clear=%b required 00",
                     {bus.load_b_o, bus.clear_xa_o});
        end
        // Load and run edge together: load wins, run edge is lost.
        @(negedge Clk);
        bus.load_i = 1'b1;
        bus.run_i  = 1'b1;
        @(negedge Clk);
        bus.load_i = 1'b0;
        #1;
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL load_priority: outputs=%b required 000000", outs());
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL held_run_no_start: busy_o=%b required 0", bus.busy_o);
        end
        bus.run_i = 1'b0;
    endtask

    task automatic test_mult_basic();
        run_mult(8'h03, 1'b1, 8'h05, 1'b0);
        release_run();
    endtask

    task automatic test_mult_sub();
        run_mult(8'h02, 1'b1, 8'h80, 1'b0);
        release_run();
    endtask

    task automatic test_hold_and_retrigger();
        run_mult(8'h07, 1'b1, 8'h03, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            checks++;
            if ({bus.done_o, bus.busy_o, bus.clear_xa_o} !== 3'b100) begin
                errors++;
                $display("FAIL done_hold: done/busy/clear=%b required 100 at cycle %0d",
                         {bus.done_o, bus.busy_o, bus.clear_xa_o}, i);
            end
        end
        release_run();
        run_mult(8'h02, 1'b0, 8'h00, 1'b0);
        release_run();
    endtask

    task automatic test_reset_mid_op();
        @(negedge Clk);
        sw = 8'h05;
        bus.load_i = 1'b1;
        @(negedge Clk);
        bus.load_i = 1'b0;
        sw = 8'h03;
        bus.run_i = 1'b1;
        // Cycle t+9 is the SHIFT of iteration 3 (cnt = 3) in the two-cycle schedule.
        repeat (9) @(negedge Clk);
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort_busy: busy_o=%b required 1", bus.busy_o);
        end
        Reset_n = 1'b0;
        bus.run_i = 1'b0;
        #1;
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL abort_immediate: outputs=%b required 000000", outs());
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL abort_hold: outputs=%b required 000000", outs());
        end
        Reset_n = 1'b1;
        run_mult(8'hFD, 1'b1, 8'h06, 1'b0);
        release_run();
    endtask

    initial begin
        test_reset();
        test_load();
        test_mult_basic();
        test_mult_sub();
        test_hold_and_retrigger();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Sequencer for the shift-add two's-complement multiplier datapath: A/X/B shift registers plus a 9-bit add/sub unit.
- Turns a debounced run level and load level into per-cycle control strobes: clear, load-A, shift, add/sub select.
- Runs exactly WIDTH add/shift iterations; the last iteration subtracts.
- Provides busy/done status for the top level and hex display logic.

Parameters:
WIDTH, 8, multiplier operand width = number of iterations (>= 2)

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
run_i  input  1  synchronized/debounced run level; rising edge starts a multiply
load_i  input  1  synchronized load/clear level (load B from switches, clear X:A)
m0_i  input  1  current LSB of B register
shift_en_o  output  1  shift X->A->B right one bit this cycle
fn_o  output  1  adder function: 0 = add, 1 = subtract (valid when load_a_o = 1)
load_a_o  output  1  load adder result into A and X
clear_xa_o  output  1  synchronous clear of A and X
load_b_o  output  1  load B from switches
busy_o  output  1  multiply in progress (CLR/ADD/SHIFT)
done_o  output  1  result valid in A:B, held until run_i released

Behaviour:
- States: IDLE, CLR, ADD, SHIFT, DONE. Iteration counter cnt is $clog2(WIDTH) bits wide.
- Rising-edge detect: run_q register; start = run_i & ~run_q.
- Reset (Reset_n = 0, asynchronous): state = IDLE, cnt = 0, run_q = 0, all outputs 0.
- IDLE:
  - load_i = 1 -> load_b_o = 1 and clear_xa_o = 1 combinationally, same cycle; stay IDLE.
  - else start -> CLR.
  - load_i has priority over start.
- CLR: clear_xa_o = 1, busy_o = 1, cnt <= 0; -> ADD.
- ADD: busy_o = 1; load_a_o = m0_i; fn_o = (cnt == WIDTH-1); -> SHIFT.
- SHIFT: shift_en_o = 1, busy_o = 1.
  - cnt == WIDTH-1 -> DONE.
  - else cnt <= cnt+1 -> ADD.
- DONE: done_o = 1. Stay while run_i = 1; run_i = 0 -> IDLE. A held run never retriggers.
- Ignored while busy or in DONE: load_i, and run_i edges.
- Timing: start sampled at edge t -> CLR in cycle t+1, ADD/SHIFT pairs in t+2..t+2WIDTH+1, DONE from t+2WIDTH+2 (WIDTH = 8: DONE at t+18).
- Outputs are decoded from state plus m0_i, load_i, cnt; no registered outputs. At most one of load_a_o and shift_en_o is high in any cycle.
- Reset mid-operation: immediate abort to IDLE. Datapath contents are don't-care; the next run starts with CLR.

Optional Feature:
MULT_SKIP_ZERO_EN
- Defined: in ADD with m0_i = 0, shift directly in the same cycle (shift_en_o = 1, load_a_o = 0). Then cnt == WIDTH-1 -> DONE, else cnt++ and stay in ADD. This makes the outputs Mealy on m0_i. Latency per multiply = 1 + WIDTH + popcount(B) cycles before DONE.
- Undefined: fixed 2-cycle iterations exactly as in Behaviour.

Decomposition:
- Package mult_pkg:
  - state enum mult_state_t {IDLE, CLR, ADD, SHIFT, DONE};
  - localparams FN_ADD = 1'b0, FN_SUB = 1'b1.
- One sub-module: run_posedge_detect (run_q flop with asynchronous active-low reset; outputs the start pulse).
- Counter stays inline.

Test Plan:
1. Reset_n low for 3 cycles mid-SHIFT at cnt = 3 -> all outputs 0 immediately (before next edge); IDLE; next run performs a full 8-iteration sequence.
2. IDLE, load_i high 1 cycle -> load_b_o = 1 and clear_xa_o = 1 that cycle only; busy_o stays 0. load_i and run edge in the same cycle -> load wins, no start.
3. WIDTH = 8, bench B model = 0x05, run edge at t -> clear_xa_o at t+1; load_a_o at iterations 0 and 2 with fn_o = 0; 8 shift_en_o pulses; done_o at t+18. Datapath product with S = 0x03 is 0x000F.
4. B = 0x80, S = 0x02 -> single load_a_o with fn_o = 1 at iteration 7; product 0xFF00 (-256).
5. run held after DONE -> done_o stays 1 for 20 cycles, no new CLR. Second run edge while busy -> ignored. Release, then press again -> new sequence, B = previous low byte.
6. MULT_SKIP_ZERO_EN defined, B = 0x05, run edge at t -> done_o at t+12; 8 shift pulses total; never load_a_o and shift_en_o in the same cycle.
